// File: rtl/iir_pkg.sv
// Shared constants and sample type for the IIR filter stage and its decimator.
package iir_pkg;

    localparam int unsigned DATA_W     = 4;
    localparam int unsigned DECIM      = 4;
    localparam int unsigned LOG2_DECIM = 2;
    localparam int unsigned ACC_W      = DATA_W + LOG2_DECIM;

    typedef logic signed [DATA_W-1:0] sample_t;

    // Output register occupancy; the encoding doubles as out_valid.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/iir_decimator_if.sv
// Sample stream from the filter plus the decimated valid/ready output and status flag.
interface iir_decimator_if #(
    parameter int unsigned DATA_W = iir_pkg::DATA_W
);

    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_ready;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     overrun;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  overrun
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output overrun
    );

endinterface

// File: rtl/iir_decim_acc.sv
// Accumulates DECIM signed samples; flags the completing sample and presents the
// floor-averaged result combinationally on that same cycle.
module iir_decim_acc #(
    parameter int unsigned DATA_W     = iir_pkg::DATA_W,
    parameter int unsigned DECIM      = iir_pkg::DECIM,
    parameter int unsigned LOG2_DECIM = iir_pkg::LOG2_DECIM,
    parameter int unsigned ACC_W      = DATA_W + LOG2_DECIM
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid_i,
    input  logic signed [DATA_W-1:0] sample_i,
    output logic                     done_o_c,
    output logic signed [DATA_W-1:0] result_o_c
);

    localparam logic [LOG2_DECIM-1:0] LAST_CNT = LOG2_DECIM'(DECIM - 1);

    logic        [LOG2_DECIM-1:0] count_q;
    logic        [LOG2_DECIM-1:0] count_d;
    logic signed [ACC_W-1:0]      acc_q;
    logic signed [ACC_W-1:0]      acc_d;
    logic signed [ACC_W-1:0]      sample_ext;
    logic signed [ACC_W-1:0]      sum;

    // Sum including the current sample; the block-closing sample seeds the result.
    always_comb begin
        sample_ext = {{(ACC_W-DATA_W){sample_i[DATA_W-1]}}, sample_i};
        sum        = acc_q + sample_ext;
        done_o_c   = sample_valid_i && (count_q == LAST_CNT);
        result_o_c = DATA_W'(sum >>> LOG2_DECIM);

        count_d = count_q;
        acc_d   = acc_q;
        if (sample_valid_i) begin
            count_d = count_q + LOG2_DECIM'(1);
            acc_d   = done_o_c ? '0 : sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            acc_q   <= '0;
        end else begin
            count_q <= count_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/iir_decimator.sv
// Decimating averager behind the IIR filter: one averaged sample per DECIM inputs,
// delivered over valid/ready; results that find the output register occupied are dropped.
module iir_decimator
    import iir_pkg::*;
#(
    parameter int unsigned DATA_W     = iir_pkg::DATA_W,
    parameter int unsigned DECIM      = iir_pkg::DECIM,
    parameter int unsigned LOG2_DECIM = iir_pkg::LOG2_DECIM,
    parameter int unsigned ACC_W      = DATA_W + LOG2_DECIM
) (
    input  logic            clk,
    input  logic            rst,
    iir_decimator_if.slave  bus
);

    out_state_e               state_q;
    out_state_e               state_d;
    logic signed [DATA_W-1:0] data_q;
    logic signed [DATA_W-1:0] data_d;
    logic                     overrun_q;
    logic                     overrun_d;
    logic                     done_c;
    logic signed [DATA_W-1:0] result_c;
    logic                     xfer_c;

    iir_decim_acc #(
        .DATA_W     (DATA_W),
        .DECIM      (DECIM),
        .LOG2_DECIM (LOG2_DECIM),
        .ACC_W      (ACC_W)
    ) u_acc (
        .clk            (clk),
        .rst            (rst),
        .sample_valid_i (bus.in_valid),
        .sample_i       (bus.in_data),
        .done_o_c       (done_c),
        .result_o_c     (result_c)
    );

    // Output register occupancy, load/drain and overrun decisions.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        xfer_c    = (state_q == OUT_FULL) && bus.out_ready;

        unique case (state_q)
            OUT_EMPTY: begin
                if (done_c) begin
                    data_d  = result_c;
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (done_c && xfer_c) begin
                    data_d = result_c;
                end else if (done_c) begin
                    overrun_d = 1'b1;
                end else if (xfer_c) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= OUT_EMPTY;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.out_valid = (state_q == OUT_FULL);
    assign bus.out_data  = data_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: doc/iir_decimator.md
Name: iir_decimator

Overview:
- Downstream neighbour of the 4-bit IIR filter stage.
- Consumes the filter's per-cycle output samples and accumulates DECIM consecutive signed samples.
- Emits their average, the accumulated sum arithmetic-shifted right by log2(DECIM), as one decimated sample over a valid/ready output handshake.
- The filter cannot stall, so the input has no backpressure. A result that cannot be delivered is dropped and flagged.

Parameters:
- DATA_W, 4, width of input and output samples (signed two's complement).
- DECIM, 4, samples per output; must be a power of two and at least 2.
- LOG2_DECIM, 2, log2(DECIM); must match DECIM.
- ACC_W, DATA_W+LOG2_DECIM, accumulator width; the sum can never overflow.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  input  1  in_data is a valid sample this cycle; tie to 1 when fed directly by the filter.
- in_data  input  DATA_W  signed sample from the IIR filter output.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_valid  output  1  out_data holds an undelivered decimated sample.
- out_data  output  DATA_W  signed decimated sample.
- overrun  output  1  sticky flag: a completed result was dropped.

Behaviour:
- Reset: when rst=1 at a clock edge, the block clears the following, regardless of any other input:
  - count=0, acc=0
  - out_valid=0, out_data=0, overrun=0
- Reset mid-block discards the partial accumulation.
- Accept: a sample is taken on every edge with in_valid=1 and rst=0. There is no input stall.
- Accumulate: in_data is sign-extended to ACC_W and added to acc. count increments by 1.
- Completion: a completion occurs when a sample is accepted while count==DECIM-1.
  - sum = acc + that sample.
  - result = sum >>> LOG2_DECIM, using an arithmetic shift that truncates toward minus infinity. Take the low DATA_W bits; the result always fits.
  - On the same edge, count wraps to 0 and acc is reset to 0. The next sample starts a fresh block and no sample is lost.
- Latency: out_valid rises on the edge that accepts the DECIM-th sample, so it is visible in the following cycle.
- Output handshake:
  - A transfer occurs on any edge with out_valid=1 and out_ready=1.
  - out_data is held stable while out_valid=1 and out_ready=0.
- Output state, two states encoded by out_valid:
  - EMPTY, completion: load out_data; out_valid=1.
  - FULL, transfer without completion: out_valid=0.
  - FULL, completion with transfer on the same edge: load the new result; out_valid stays 1; no overrun.
  - FULL, completion without transfer: the new result is dropped; out_data is unchanged; overrun is set to 1.
- overrun clears only on rst.
- in_valid=0 cycles: acc, count and all outputs hold.
- out_ready is ignored when out_valid=0.

Decomposition:
- Shared package iir_pkg:
  - constants DATA_W=4, DECIM=4, LOG2_DECIM=2
  - a signed sample typedef of DATA_W bits, shared with the filter stage.
- One natural sub-module, iir_decim_acc:
  - contains the count and accumulator and produces a completion pulse plus result.
  - the top level holds the output register, handshake and overrun logic.

Test Plan:
- Basic average, DECIM=4: inputs 1,2,3,4 on consecutive cycles with out_ready=1. Sum is 10, so one cycle after the 4th sample out_valid=1 and out_data=2 for exactly one cycle.
- Negative rounding: inputs -1,-1,-1,-2. Sum is -5, so out_data=-2 (4'hE), not -1.
- Extremes: four samples of 7 give out_data=7. Four samples of -8 give out_data=-8 (4'h8). No wrap in either case.
- Overrun: out_ready=0, samples 1,1,1,1 then 5,5,5,5.
  - After the first block, out_data=1 and out_valid=1.
  - After the second block, out_data is still 1 and overrun=1.
  - Raising out_ready gives one transfer of 1; out_valid then drops. overrun stays 1 until rst.
- Simultaneous drain and completion: the first result (1) is pending.
  - Assert out_ready on the edge that completes a block of 6,6,6,6.
  - out_data becomes 6, out_valid stays 1, overrun stays 0.
- Reset mid-block: feed 7,7, assert rst for one cycle, then feed 4,4,4,4.
  - All outputs are 0 during reset.
  - The result is out_data=4, confirming the partial sum was discarded.
  - Also check in_valid=0 gaps inside a block do not change the result.
